terminal_port_arbiter: RTL and testbench
========================================

// Module: terminal_port_arbiter
// PURPOSE
// Owns the single text-RAM port of the Terminal and shares it between the debugger's
// write stream and a CPU memory-mapped console port (read/write).
// Contains a clear sequencer that fills every text cell with FILL_CHAR after reset or on request.
// Sits between debugger/CPU bus glue and Terminal.textAddress/textWriteData/textReadData.
// PARAMETERS
// CELL_COUNT      2400   number of valid text cells (80x30); addresses >= CELL_COUNT are out of range
// FILL_CHAR       8'h20  character written by the clear sequencer
// CLEAR_ON_RESET  1      1: enter CLEAR on reset release; 0: enter IDLE
// PORTS
// clock           in   1   system clock (clock50Mhz domain)
// reset           in   1   asynchronous, active-low reset (asserted when 0)
// clear_req       in   1   one-cycle pulse: start screen clear
// clear_busy      out  1   high while the clear sequencer owns the port
// cpu_req         in   1   CPU access request; held until cpu_ack
// cpu_write       in   1   1=write, 0=read; stable while cpu_req high
// cpu_addr        in   12  CPU cell address
// cpu_wdata       in   8   CPU write character
// cpu_ack         out  1   one-cycle completion pulse; for reads, cpu_rdata is valid in the same cycle
// cpu_rdata       out  8   read character; holds its value until the next read completes
// dbg_req         in   1   debugger write request; held until dbg_ack
// dbg_addr        in   12  debugger cell address
// dbg_data        in   8   debugger character
// dbg_ack         out  1   one-cycle completion pulse
// terminal_addr   out  12  text RAM address (registered)
// terminal_write  out  1   text RAM write enable (registered, one-cycle pulses)
// terminal_data   out  8   text RAM write data (registered)
// terminal_rdata  in   8   text RAM read data, synchronous, valid 1 cycle after terminal_addr
// BEHAVIOUR
// - Reset (async, while reset==0) drives these values:
//   all acks 0, terminal_write 0, terminal_addr 0, terminal_data 0, cpu_rdata 0.
//   Clear counter = 0. State = CLEAR if CLEAR_ON_RESET, else IDLE. clear_busy follows state.
// - A transaction in flight when reset is asserted is abandoned: no ack is issued.
// - States: CLEAR, IDLE, WACK, RADDR, RDATA.
// - CLEAR: one write per cycle.
//   terminal_addr = counter, terminal_data = FILL_CHAR, terminal_write = 1.
//   The counter runs 0..CELL_COUNT-1; after the last cell, go to IDLE.
//   clear_busy = 1 throughout. Requests are not acked; requesters keep waiting.
//   clear_req pulses during CLEAR are ignored (no restart).
// - IDLE: sample requests in cycle N.
//   Neither requesting: stay in IDLE, terminal_write = 0.
//   One requesting: grant it.
//   Both requesting: round-robin. Grant the requester not granted last.
//   The last-grant flag resets to dbg, so the CPU wins the first tie.
//   Grant write (dbg, or cpu with cpu_write=1): register addr/data and write=1, visible in N+1.
//   Matching ack = 1 in N+1 (state WACK). Return to IDLE in N+2.
//   Grant CPU read: register terminal_addr, write=0 (RADDR in N+1).
//   RDATA in N+2: cpu_rdata <= terminal_rdata and cpu_ack = 1. IDLE in N+3.
// - Throughput: writes 1 per 2 cycles, reads 1 per 3 cycles. No request is acked twice.
// - Out of range (addr >= CELL_COUNT): the write is suppressed (terminal_write stays 0)
//   but the ack still follows the normal timing. A read returns 8'h00.
// - clear_req outside CLEAR: latch a pending flag. The current transaction completes
//   (its ack is issued). Then enter CLEAR with counter=0 instead of arbitrating.
// - clear_req arriving in the same IDLE cycle as a request: CLEAR wins, and the request waits.
// - terminal_write is never asserted in IDLE, RADDR or RDATA.
// STRUCTURE
// - Shared package terminal_pkg:
//   state encodings, TEXT_ADDR_W=12, TEXT_DATA_W=8, default CELL_COUNT and FILL_CHAR.
// - Sub-module rr_arbiter2: two requests, last-grant register, one-hot grant. Grant updates only on an accepted transaction.
// - The FSM, clear counter and port output registers live in this module.
// TESTING
// - Reset release (CLEAR_ON_RESET=1) -> exactly 2400 writes of 8'h20 to addrs 0..2399 on
//   consecutive cycles. clear_busy falls the cycle after addr 2399. No acks during the clear.
// - dbg write 0x005/'A' alone -> terminal_write=1, addr=0x005, data=8'h41 in N+1;
//   dbg_ack pulse in N+1. A held dbg_req is not re-granted in N+1.
// - cpu and dbg both request continuously for 8 grants -> strict alternation cpu, dbg, cpu...
//   Each ack is exactly one cycle long.
// - cpu read 0x010 with the model RAM holding 8'h5A -> cpu_ack and cpu_rdata=8'h5A in N+2,
//   with terminal_write=0 throughout.
// - cpu write to 0x960 (2400) -> no terminal_write, cpu_ack still in N+1.
//   A cpu read of 0x FFF returns 8'h00.
// - clear_req in the WACK cycle of a dbg write -> dbg_ack still issued, then CLEAR starts at addr 0.
//   Async reset during CLEAR at addr 1000 -> outputs zero immediately, and the clear restarts at 0.

Source files
------------

// File: rtl/terminal_pkg.sv
// Shared types and constants for the terminal text-RAM port arbiter.
package terminal_pkg;

  localparam int TEXT_ADDR_W = 12;
  localparam int TEXT_DATA_W = 8;

  localparam int                     DEFAULT_CELL_COUNT = 2400;
  localparam logic [TEXT_DATA_W-1:0] DEFAULT_FILL_CHAR  = 8'h20;

  // Bit positions inside the two-entry request/grant vectors.
  localparam int REQ_CPU = 0;
  localparam int REQ_DBG = 1;

  typedef enum logic [2:0] {
    ST_CLEAR,
    ST_IDLE,
    ST_WACK,
    ST_RADDR,
    ST_RDATA
  } state_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter: one-hot grant, last-grant flag moves only on accepted grants.
module rr_arbiter2
  import terminal_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       accept,
  output logic [1:0] grant
);

  logic last_dbg_q;

  // NOTE: combinational outputs get a default before any branch so no latch is inferred.
  always_comb begin
    grant = 2'b00;
    if (req[REQ_CPU] && req[REQ_DBG]) begin
      grant[REQ_CPU] = last_dbg_q;
      grant[REQ_DBG] = !last_dbg_q;
    end else begin
      grant = req;
    end
  end

  // Starts as "dbg granted last" so the CPU wins the first tie.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      last_dbg_q <= 1'b1;
    end else if (accept && (grant != 2'b00)) begin
      last_dbg_q <= grant[REQ_DBG];
    end
  end

endmodule

// File: rtl/terminal_port_arbiter.sv
// Shares the terminal text-RAM port between debugger writes, CPU console accesses
// and a screen-clear sequencer.
module terminal_port_arbiter
  import terminal_pkg::*;
#(
  parameter int                     CELL_COUNT     = DEFAULT_CELL_COUNT,
  parameter logic [TEXT_DATA_W-1:0] FILL_CHAR      = DEFAULT_FILL_CHAR,
  parameter bit                     CLEAR_ON_RESET = 1'b1
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   clear_req,
  output logic                   clear_busy,
  input  logic                   cpu_req,
  input  logic                   cpu_write,
  input  logic [TEXT_ADDR_W-1:0] cpu_addr,
  input  logic [TEXT_DATA_W-1:0] cpu_wdata,
  output logic                   cpu_ack,
  output logic [TEXT_DATA_W-1:0] cpu_rdata,
  input  logic                   dbg_req,
  input  logic [TEXT_ADDR_W-1:0] dbg_addr,
  input  logic [TEXT_DATA_W-1:0] dbg_data,
  output logic                   dbg_ack,
  output logic [TEXT_ADDR_W-1:0] terminal_addr,
  output logic                   terminal_write,
  output logic [TEXT_DATA_W-1:0] terminal_data,
  input  logic [TEXT_DATA_W-1:0] terminal_rdata
);

  localparam logic [TEXT_ADDR_W-1:0] CELL_LIMIT  = TEXT_ADDR_W'(CELL_COUNT);
  localparam state_t                 RESET_STATE = CLEAR_ON_RESET ? ST_CLEAR : ST_IDLE;

  state_t state_q, state_d;

  logic [TEXT_ADDR_W-1:0] clear_cnt_q, clear_cnt_d;
  logic                   clear_pending_q, clear_pending_d;
  logic [TEXT_ADDR_W-1:0] addr_q, addr_d;
  logic [TEXT_DATA_W-1:0] data_q, data_d;
  logic                   write_q, write_d;
  logic                   cpu_ack_q, cpu_ack_d;
  logic                   dbg_ack_q, dbg_ack_d;
  logic                   rd_oor_q, rd_oor_d;
  logic [TEXT_DATA_W-1:0] rdata_q, rdata_d;

  logic [1:0] req;
  logic [1:0] grant;
  logic       clear_wanted;
  logic       accept;

  function automatic logic in_range(input logic [TEXT_ADDR_W-1:0] addr);
    return addr < CELL_LIMIT;
  endfunction

  // A pending or same-cycle clear pre-empts arbitration in IDLE.
  assign clear_wanted = clear_req || clear_pending_q;
  assign req          = {dbg_req, cpu_req};
  assign accept       = (state_q == ST_IDLE) && !clear_wanted;

  rr_arbiter2 u_rr (
    .clock  (clock),
    .reset  (reset),
    .req    (req),
    .accept (accept),
    .grant  (grant)
  );

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= RESET_STATE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_CLEAR: if (clear_cnt_q == CELL_LIMIT) state_d = ST_IDLE;
      ST_IDLE: begin
        if (clear_wanted)          state_d = ST_CLEAR;
        else if (grant[REQ_DBG])   state_d = ST_WACK;
        else if (grant[REQ_CPU])   state_d = cpu_write ? ST_WACK : ST_RADDR;
      end
      ST_WACK:  state_d = ST_IDLE;
      ST_RADDR: state_d = ST_RDATA;
      ST_RDATA: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Next values of the port registers. The clear counter counts issued writes,
  // so the cycle showing the last cell still reports clear_busy.
  always_comb begin
    addr_d          = addr_q;
    data_d          = data_q;
    write_d         = 1'b0;
    cpu_ack_d       = 1'b0;
    dbg_ack_d       = 1'b0;
    rd_oor_d        = rd_oor_q;
    rdata_d         = rdata_q;
    clear_cnt_d     = clear_cnt_q;
    clear_pending_d = clear_pending_q || (clear_req && (state_q != ST_CLEAR));
    case (state_q)
      ST_CLEAR: begin
        if (clear_cnt_q != CELL_LIMIT) begin
          addr_d      = clear_cnt_q;
          data_d      = FILL_CHAR;
          write_d     = 1'b1;
          clear_cnt_d = clear_cnt_q + 1'b1;
        end
      end
      ST_IDLE: begin
        if (clear_wanted) begin
          clear_cnt_d     = '0;
          clear_pending_d = 1'b0;
        end else if (grant[REQ_DBG]) begin
          addr_d    = dbg_addr;
          data_d    = dbg_data;
          write_d   = in_range(dbg_addr);
          dbg_ack_d = 1'b1;
        end else if (grant[REQ_CPU]) begin
          addr_d = cpu_addr;
          if (cpu_write) begin
            data_d    = cpu_wdata;
            write_d   = in_range(cpu_addr);
            cpu_ack_d = 1'b1;
          end else begin
            rd_oor_d = !in_range(cpu_addr);
          end
        end
      end
      ST_RADDR: cpu_ack_d = 1'b1;
      ST_RDATA: rdata_d   = cpu_rdata;
      default: ;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      addr_q          <= '0;
      data_q          <= '0;
      write_q         <= 1'b0;
      cpu_ack_q       <= 1'b0;
      dbg_ack_q       <= 1'b0;
      rd_oor_q        <= 1'b0;
      rdata_q         <= '0;
      clear_cnt_q     <= '0;
      clear_pending_q <= 1'b0;
    end else begin
      addr_q          <= addr_d;
      data_q          <= data_d;
      write_q         <= write_d;
      cpu_ack_q       <= cpu_ack_d;
      dbg_ack_q       <= dbg_ack_d;
      rd_oor_q        <= rd_oor_d;
      rdata_q         <= rdata_d;
      clear_cnt_q     <= clear_cnt_d;
      clear_pending_q <= clear_pending_d;
    end
  end

  // RAM data arrives in the RDATA cycle itself, so it bypasses the hold register there.
  assign cpu_rdata      = (state_q == ST_RDATA) ? (rd_oor_q ? '0 : terminal_rdata) : rdata_q;
  assign cpu_ack        = cpu_ack_q;
  assign dbg_ack        = dbg_ack_q;
  assign terminal_addr  = addr_q;
  assign terminal_write = write_q;
  assign terminal_data  = data_q;
  assign clear_busy     = (state_q == ST_CLEAR);

endmodule

// File: tb/tb_terminal_port_arbiter.sv
// Self-checking bench for terminal_port_arbiter: directed vectors, corner sequences and
// randomized traffic checked against a shadow copy of the screen.
module tb_terminal_port_arbiter;
  import terminal_pkg::*;

  localparam int CELLS = 2400;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       clear_req = 1'b0;
  logic       clear_busy;
  logic       cpu_req = 1'b0, cpu_write = 1'b0;
  logic [11:0] cpu_addr = '0;
  logic [7:0]  cpu_wdata = '0;
  logic        cpu_ack;
  logic [7:0]  cpu_rdata;
  logic        dbg_req = 1'b0;
  logic [11:0] dbg_addr = '0;
  logic [7:0]  dbg_data = '0;
  logic        dbg_ack;
  logic [11:0] terminal_addr;
  logic        terminal_write;
  logic [7:0]  terminal_data;
  logic [7:0]  terminal_rdata = '0;

  logic [7:0] mem    [0:4095];
  logic [7:0] shadow [0:4095];

  int checks = 0;
  int errors = 0;

  terminal_port_arbiter dut (
    .clock          (clock),
    .reset          (reset),
    .clear_req      (clear_req),
    .clear_busy     (clear_busy),
    .cpu_req        (cpu_req),
    .cpu_write      (cpu_write),
    .cpu_addr       (cpu_addr),
    .cpu_wdata      (cpu_wdata),
    .cpu_ack        (cpu_ack),
    .cpu_rdata      (cpu_rdata),
    .dbg_req        (dbg_req),
    .dbg_addr       (dbg_addr),
    .dbg_data       (dbg_data),
    .dbg_ack        (dbg_ack),
    .terminal_addr  (terminal_addr),
    .terminal_write (terminal_write),
    .terminal_data  (terminal_data),
    .terminal_rdata (terminal_rdata)
  );

  always #5 clock = ~clock;

  // Synchronous text RAM: read data valid one cycle after the address.
  always @(posedge clock) begin
    if (terminal_write) mem[terminal_addr] <= terminal_data;
    terminal_rdata <= mem[terminal_addr];
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, actual, expected);
    end
  endtask

  task automatic monitor_clear(output int n_wr, output int bad, output int first,
                               output int last, output int fall, output int acks);
    n_wr = 0; bad = 0; first = -1; last = -1; fall = -1; acks = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clock);
      if (!clear_busy) begin
        fall = cyc;
        break;
      end
      if (cpu_ack || dbg_ack) acks++;
      if (terminal_write) begin
        if (terminal_addr !== 12'(n_wr) || terminal_data !== 8'h20) bad++;
        if (first < 0) first = cyc;
        last = cyc;
        n_wr++;
      end
    end
  endtask

  task automatic check_clear(input string tag);
    int n_wr, bad, first, last, fall, acks;
    monitor_clear(n_wr, bad, first, last, fall, acks);
    check({tag, "_write_count"}, n_wr, CELLS);
    check({tag, "_addr_data_seq"}, bad, 0);
    check({tag, "_consecutive"}, last - first, CELLS - 1);
    check({tag, "_busy_fall"}, fall, last + 1);
    check({tag, "_no_acks"}, acks, 0);
    check({tag, "_no_write_idle"}, terminal_write, 0);
  endtask

  typedef struct {
    bit          is_dbg;
    bit          wr;
    logic [11:0] addr;
    logic [7:0]  data;
    bit          exp_tw;
    int          exp_lat;
    logic [7:0]  exp_rdata;
  } vec_t;

  vec_t vecs [12];

  initial begin
    int lat, k_seen;
    bit saw_w, other;
    logic [11:0] wa;
    logic [7:0] wd, rd;
    int seq [8];
    int n_g, last_ack_cyc, bad_spacing, overlap;
    bit c_act, d_act, c_wr;
    logic [11:0] c_addr, d_addr;
    logic [7:0] c_data, d_data;
    int c_age, d_age, n_done, tw_seen, tw_exp, mism;

    //             dbg  wr  addr    data   tw lat rdata
    vecs[0]  = '{1'b1, 1'b1, 12'h005, 8'h41, 1'b1, 1, 8'h00};
    vecs[1]  = '{1'b0, 1'b1, 12'h010, 8'h5A, 1'b1, 1, 8'h00};
    vecs[2]  = '{1'b0, 1'b0, 12'h010, 8'h00, 1'b0, 2, 8'h5A};
    vecs[3]  = '{1'b0, 1'b1, 12'h960, 8'h33, 1'b0, 1, 8'h00};
    vecs[4]  = '{1'b0, 1'b0, 12'hFFF, 8'h00, 1'b0, 2, 8'h00};
    vecs[5]  = '{1'b1, 1'b1, 12'h95F, 8'h7E, 1'b1, 1, 8'h00};
    vecs[6]  = '{1'b0, 1'b0, 12'h95F, 8'h00, 1'b0, 2, 8'h7E};
    vecs[7]  = '{1'b1, 1'b1, 12'h960, 8'h11, 1'b0, 1, 8'h00};
    vecs[8]  = '{1'b0, 1'b0, 12'h005, 8'h00, 1'b0, 2, 8'h41};
    vecs[9]  = '{1'b0, 1'b0, 12'h200, 8'h00, 1'b0, 2, 8'h20};
    vecs[10] = '{1'b0, 1'b0, 12'h960, 8'h00, 1'b0, 2, 8'h00};
    vecs[11] = '{1'b1, 1'b1, 12'h030, 8'h44, 1'b1, 1, 8'h00};

    // Reset values.
    repeat (3) @(negedge clock);
    check("rst_twrite", terminal_write, 0);
    check("rst_taddr", terminal_addr, 0);
    check("rst_tdata", terminal_data, 0);
    check("rst_acks", {cpu_ack, dbg_ack}, 0);
    check("rst_rdata", cpu_rdata, 0);
    check("rst_busy", clear_busy, 1);

    // Release reset with a CPU read already waiting; it must be held off by the clear.
    cpu_req = 1'b1; cpu_write = 1'b0; cpu_addr = 12'h123;
    reset = 1'b1;
    check_clear("clr0");
    lat = 0;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clock);
      if (cpu_ack) begin lat = k; rd = cpu_rdata; break; end
    end
    cpu_req = 1'b0;
    check("clr0_waiting_read_lat", lat, 2);
    check("clr0_waiting_read_data", rd, 8'h20);
    @(negedge clock);
    for (int a = 0; a < 4096; a++) shadow[a] = (a < CELLS) ? 8'h20 : 8'h00;

    // Directed single transactions.
    for (int i = 0; i < 12; i++) begin
      lat = 0; saw_w = 1'b0; other = 1'b0; wa = '0; wd = '0; rd = '0;
      if (vecs[i].is_dbg) begin
        dbg_req = 1'b1; dbg_addr = vecs[i].addr; dbg_data = vecs[i].data;
      end else begin
        cpu_req = 1'b1; cpu_write = vecs[i].wr; cpu_addr = vecs[i].addr; cpu_wdata = vecs[i].data;
      end
      for (int k = 1; k <= 8; k++) begin
        @(negedge clock);
        if (terminal_write) begin saw_w = 1'b1; wa = terminal_addr; wd = terminal_data; end
        if (vecs[i].is_dbg ? cpu_ack : dbg_ack) other = 1'b1;
        if (vecs[i].is_dbg ? dbg_ack : cpu_ack) begin lat = k; rd = cpu_rdata; break; end
      end
      cpu_req = 1'b0; dbg_req = 1'b0;
      @(negedge clock);
      check($sformatf("vec%0d_latency", i), lat, vecs[i].exp_lat);
      check($sformatf("vec%0d_twrite", i), saw_w, vecs[i].exp_tw);
      if (vecs[i].exp_tw) begin
        check($sformatf("vec%0d_taddr", i), wa, vecs[i].addr);
        check($sformatf("vec%0d_tdata", i), wd, vecs[i].data);
      end
      if (!vecs[i].wr) check($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rdata);
      check($sformatf("vec%0d_ack_one_cycle", i), {cpu_ack, dbg_ack, other}, 0);
      if (vecs[i].wr && vecs[i].addr < CELLS) shadow[vecs[i].addr] = vecs[i].data;
    end

    // Both requesting continuously: strict alternation starting with the CPU.
    cpu_req = 1'b1; cpu_write = 1'b1; cpu_addr = 12'h020; cpu_wdata = 8'h63;
    dbg_req = 1'b1; dbg_addr = 12'h021; dbg_data = 8'h64;
    n_g = 0; last_ack_cyc = -1; bad_spacing = 0; overlap = 0;
    for (int cyc = 0; cyc < 40 && n_g < 8; cyc++) begin
      @(negedge clock);
      if (cpu_ack && dbg_ack) overlap++;
      if (cpu_ack || dbg_ack) begin
        if (last_ack_cyc >= 0 && cyc - last_ack_cyc != 2) bad_spacing++;
        last_ack_cyc = cyc;
        seq[n_g] = dbg_ack ? 1 : 0;
        n_g++;
      end
    end
    cpu_req = 1'b0; dbg_req = 1'b0;
    check("alt_grant_count", n_g, 8);
    for (int i = 0; i < 8; i++) check($sformatf("alt_grant%0d", i), seq[i], i % 2);
    check("alt_ack_spacing", bad_spacing, 0);
    check("alt_ack_overlap", overlap, 0);
    shadow[12'h020] = 8'h63; shadow[12'h021] = 8'h64;
    repeat (2) @(negedge clock);

    // Randomized traffic against the shadow screen.
    c_act = 0; d_act = 0; c_age = 0; d_age = 0; n_done = 0; tw_seen = 0; tw_exp = 0;
    c_wr = 0; c_addr = '0; c_data = '0; d_addr = '0; d_data = '0;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      @(negedge clock);
      if (n_done >= 300 && !c_act && !d_act) break;
      if (terminal_write) tw_seen++;
      if (cpu_ack) begin
        check("rnd_cpu_ack_expected", c_act, 1);
        if (c_act) begin
          if (c_wr) begin
            if (c_addr < CELLS) begin
              check("rnd_cpu_wr_port", {terminal_write, terminal_addr, terminal_data}, {1'b1, c_addr, c_data});
              shadow[c_addr] = c_data;
              tw_exp++;
            end else check("rnd_cpu_wr_oor", terminal_write, 0);
          end else check("rnd_cpu_rd", cpu_rdata, (c_addr < CELLS) ? shadow[c_addr] : 8'h00);
          c_act = 0; cpu_req = 1'b0; n_done++;
        end
      end
      if (dbg_ack) begin
        check("rnd_dbg_ack_expected", d_act, 1);
        if (d_act) begin
          if (d_addr < CELLS) begin
            check("rnd_dbg_wr_port", {terminal_write, terminal_addr, terminal_data}, {1'b1, d_addr, d_data});
            shadow[d_addr] = d_data;
            tw_exp++;
          end else check("rnd_dbg_wr_oor", terminal_write, 0);
          d_act = 0; dbg_req = 1'b0; n_done++;
        end
      end
      if (c_act) begin
        c_age++;
        if (c_age > 12) begin check("rnd_cpu_timeout", c_age, 12); c_act = 0; cpu_req = 1'b0; end
      end
      if (d_act) begin
        d_age++;
        if (d_age > 12) begin check("rnd_dbg_timeout", d_age, 12); d_act = 0; dbg_req = 1'b0; end
      end
      if (!c_act && n_done < 300 && $urandom_range(0, 3) != 0) begin
        c_act = 1; c_age = 0;
        c_wr = 1'($urandom_range(0, 1));
        c_addr = ($urandom_range(0, 9) == 0) ? 12'($urandom_range(CELLS, 4095)) : 12'($urandom_range(0, 63));
        c_data = 8'($urandom_range(0, 255));
        cpu_req = 1'b1; cpu_write = c_wr; cpu_addr = c_addr; cpu_wdata = c_data;
      end
      if (!d_act && n_done < 300 && $urandom_range(0, 3) != 0) begin
        d_act = 1; d_age = 0;
        d_addr = ($urandom_range(0, 9) == 0) ? 12'($urandom_range(CELLS, 4095)) : 12'($urandom_range(0, 63));
        d_data = 8'($urandom_range(0, 255));
        dbg_req = 1'b1; dbg_addr = d_addr; dbg_data = d_data;
      end
    end
    cpu_req = 1'b0; dbg_req = 1'b0;
    check("rnd_done", n_done >= 300, 1);
    check("rnd_write_count", tw_seen, tw_exp);
    repeat (2) @(negedge clock);
    mism = 0;
    for (int a = 0; a < CELLS; a++) if (mem[a] !== shadow[a]) mism++;
    check("rnd_screen_contents", mism, 0);

    // clear_req during the WACK cycle of a debugger write.
    dbg_req = 1'b1; dbg_addr = 12'h040; dbg_data = 8'h55;
    k_seen = 0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clock);
      if (dbg_ack) begin k_seen = k; break; end
    end
    clear_req = 1'b1; dbg_req = 1'b0;
    check("wack_clear_dbg_ack", k_seen, 1);
    @(negedge clock);
    clear_req = 1'b0;
    k_seen = 0;
    for (int k = 1; k <= 10; k++) begin
      if (clear_busy) begin k_seen = k; break; end
      @(negedge clock);
    end
    check("wack_clear_started", k_seen != 0, 1);
    wa = 12'hFFF;
    for (int k = 0; k < 10; k++) begin
      if (terminal_write) begin wa = terminal_addr; break; end
      @(negedge clock);
    end
    check("wack_clear_first_addr", wa, 0);

    // Async reset in the middle of the clear, then a full restart from address 0.
    k_seen = 0;
    for (int k = 0; k < 1200; k++) begin
      if (terminal_write && terminal_addr == 12'd1000) begin k_seen = 1; break; end
      @(negedge clock);
    end
    check("midclear_reached_1000", k_seen, 1);
    reset = 1'b0;
    #1;
    check("midrst_twrite", terminal_write, 0);
    check("midrst_taddr", terminal_addr, 0);
    check("midrst_tdata", terminal_data, 0);
    check("midrst_acks", {cpu_ack, dbg_ack}, 0);
    check("midrst_rdata", cpu_rdata, 0);
    @(negedge clock);
    reset = 1'b1;
    check_clear("clr1");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
